dense_transpose_mac: RTL
========================

// Module: dense_transpose_mac
//
// PURPOSE
//   Backward-direction companion of the dense latency layer: computes y = W^T * g, where g is an
//   OUTPUT_SIZE vector (e.g. an output-side gradient) and W uses the same flattened
//   (INPUT_SIZE, OUTPUT_SIZE) weight layout as the forward layer. Produces an INPUT_SIZE vector.
//   The block is time-multiplexed: one column of W per cycle, INPUT_SIZE parallel MACs.
//   It uses a valid/ready handshake on both sides.
//
// PARAMETERS
//   WIDTH       17  signed fixed-point word width, same for data, weights and results
//   NFRAC       10  fractional bits; product rescaled by slicing [WIDTH+NFRAC-1:NFRAC]
//   INPUT_SIZE  32  forward-layer input count = length of out_data
//   OUTPUT_SIZE 1   forward-layer output count = length of in_data = accumulate cycles
//
// PORTS
//   clk        in   1                        clock
//   reset      in   1                        asynchronous, active-high reset
//   in_valid   in   1                        in_data/weights presented
//   in_ready   out  1                        block can accept; high only in IDLE
//   in_data    in   WIDTH x OUTPUT_SIZE      signed vector g[k]
//   weights    in   WIDTH x IN*OUT           signed W flattened; W[i][k] = weights[i*OUTPUT_SIZE+k]
//   out_valid  out  1                        out_data holds a complete result
//   out_ready  in   1                        downstream accepts out_data
//   out_data   out  WIDTH x INPUT_SIZE       signed y[i] = sum_k W[i][k]*g[k]
//   busy       out  1                        high in ACC or DONE
//
// BEHAVIOUR
//   - Reset (any time, including mid-ACC or DONE): state=IDLE, k=0, accumulators=0, out_data=0,
//     out_valid=0, busy=0. The in-flight operation is discarded. in_ready=1 once reset deasserts.
//   - FSM IDLE -> ACC -> DONE -> IDLE.
//     IDLE: in_ready=1. On an edge with in_valid&&in_ready: latch in_data and weights, clear
//       accumulators, k<=0, go to ACC. Inputs may change freely after that edge.
//     ACC: for every i, acc[i] <= acc[i] + slice(W[i][k]*g[k]). k increments each cycle.
//       After the edge with k==OUTPUT_SIZE-1: copy acc to out_data and go to DONE.
//       This takes exactly OUTPUT_SIZE edges.
//     DONE: out_valid=1, out_data stable. On an edge with out_ready: go to IDLE and drop out_valid.
//       While out_ready=0, the block holds indefinitely. in_valid is ignored.
//   - Latency: with the accept handshake at edge E, out_valid rises after edge E+OUTPUT_SIZE.
//     Minimum spacing between accepts is OUTPUT_SIZE+2 cycles.
//     in_ready is never high while out_valid is high.
//   - OUTPUT_SIZE==1: ACC lasts one edge; the same rules apply.
//   - Arithmetic: full 2*WIDTH signed product, sliced to [WIDTH+NFRAC-1:NFRAC] (floor, no rounding).
//     Accumulation is WIDTH-bit two's-complement with wrap and no saturation.
//     This is bit-exact with the forward layer's per-term rescale.
//   - out_data changes only on the ACC->DONE edge or at reset.
//
// TESTING (WIDTH=8, INPUT_SIZE=3, OUTPUT_SIZE=2, weights=[1,2,3,4,5,6] unless noted)
//   1. NFRAC=0, g=[2,3], out_ready=1 -> out_data=[8,18,28]. out_valid rises 2 edges after accept.
//      Pulse lasts 1 cycle; in_ready is high again the next cycle.
//   2. NFRAC=0, g=[1,-1] -> out_data=[-1,-1,-1]. Checks signed products.
//   3. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_data and busy stay constant.
//      in_ready=0 and a second in_valid is not accepted. Release -> one transfer, then IDLE.
//   4. Wrap: weights all 1, g=[100,100], NFRAC=0 -> out_data=[-56,-56,-56].
//   5. NFRAC=4: g=[16,0], W[i][0]=8 for all i -> out_data=[8,8,8]. g=[1,0], W[i][0]=1 -> [0,0,0] (floor).
//   6. Async reset asserted mid-ACC (k=1), no clock edge -> out_valid=0, busy=0 immediately.
//      After release, a fresh g=[2,3] gives [8,18,28] with no residue from the aborted run.

Source files
------------

// File: rtl/dense_transpose_mac_if.sv
// Handshake bundle for dense_transpose_mac: operand side (g, W) and
// result side (y), each with its own valid/ready pair.
interface dense_transpose_mac_if #(
    parameter int WIDTH       = 17,
    parameter int INPUT_SIZE  = 32,
    parameter int OUTPUT_SIZE = 1
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [OUTPUT_SIZE*WIDTH-1:0]            in_data;
    logic [INPUT_SIZE*OUTPUT_SIZE*WIDTH-1:0] weights;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [INPUT_SIZE*WIDTH-1:0]             out_data;
    logic                                    busy;

    modport master (
        output in_valid, in_data, weights, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, weights, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/dense_transpose_mac.sv
// dense_transpose_mac: y = W^T * g, one column of W per cycle,
// INPUT_SIZE parallel MACs behind valid/ready handshakes.
module dense_transpose_mac #(
    parameter int WIDTH       = 17,
    parameter int NFRAC       = 10,
    parameter int INPUT_SIZE  = 32,
    parameter int OUTPUT_SIZE = 1
) (
    input logic                  clk,
    input logic                  reset,
    dense_transpose_mac_if.slave bus
);
    localparam int KW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                  state;
    state_t                  nstate;
    logic [KW-1:0]           k;
    logic                    last;
    logic signed [WIDTH-1:0] g_q  [OUTPUT_SIZE];
    logic signed [WIDTH-1:0] w_q  [INPUT_SIZE][OUTPUT_SIZE];
    logic signed [WIDTH-1:0] acc  [INPUT_SIZE];
    logic signed [WIDTH-1:0] sum  [INPUT_SIZE];
    logic signed [WIDTH-1:0] wsel [INPUT_SIZE];
    logic signed [WIDTH-1:0] gsel;
    logic [INPUT_SIZE*WIDTH-1:0] out_q;

    assign last         = (k == KW'(OUTPUT_SIZE - 1));
    assign bus.out_data = out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  nstate = ACC;
            ACC:     if (last)          nstate = DONE;
            DONE:    if (bus.out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state)
            IDLE:    bus.in_ready = 1'b1;
            ACC:     bus.busy     = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    // Column k of W and element k of g feed every MAC this cycle.
    always_comb begin
        gsel = '0;
        for (int i = 0; i < INPUT_SIZE; i++) wsel[i] = '0;
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            if (k == KW'(j)) begin
                gsel = g_q[j];
                for (int i = 0; i < INPUT_SIZE; i++) wsel[i] = w_q[i][j];
            end
        end
    end

    // Floor rescale keeps product bits [WIDTH+NFRAC-1:NFRAC]; add wraps.
    always_comb begin
        for (int i = 0; i < INPUT_SIZE; i++) begin
            sum[i] = acc[i]
                   + WIDTH'((PW'(wsel[i]) * PW'(gsel)) >>> NFRAC);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k     <= '0;
            out_q <= '0;
            for (int j = 0; j < OUTPUT_SIZE; j++) g_q[j] <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                acc[i] <= '0;
                for (int j = 0; j < OUTPUT_SIZE; j++) w_q[i][j] <= '0;
            end
        end else if (state == IDLE && bus.in_valid) begin
            k <= '0;
            for (int j = 0; j < OUTPUT_SIZE; j++) begin
                g_q[j] <= bus.in_data[j*WIDTH +: WIDTH];
            end
            for (int i = 0; i < INPUT_SIZE; i++) begin
                acc[i] <= '0;
                for (int j = 0; j < OUTPUT_SIZE; j++) begin
                    w_q[i][j] <= bus.weights[(i*OUTPUT_SIZE+j)*WIDTH +: WIDTH];
                end
            end
        end else if (state == ACC) begin
            k <= k + 1'b1;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                acc[i] <= sum[i];
                if (last) out_q[i*WIDTH +: WIDTH] <= sum[i];
            end
        end
    end
endmodule
